step_id: RTL
============

// Module: step_id
// PURPOSE
//  Instruction dispatch step, directly upstream of the execute steps (step_ex_*).
//  Takes a fetched 8-bit instruction on a one-cycle ena_ strobe from the fetch step.
//  Pulses the ena_ of exactly one execute step, then waits for that step's rdy_.
//  Returns rdy_ to the fetch step.
//  All strobe outputs are open-drain style: driven 1'b0 when active, 1'bZ otherwise.
// PARAMETERS
//  TIMEOUT  8'd255  WAIT-state cycles before declaring a hung execute step (1..255)
//  NOP_OP   3'd7    opcode completed internally; no execute step is enabled
// PORTS
//  clk      in   1  clock; all state updates on posedge
//  rst_     in   1  asynchronous active-low reset
//  ena_     in   1  start strobe from fetch step, sampled on posedge
//  rdy_     out  1  done strobe to fetch step; 0 for one cycle, else Z
//  ins      in   8  instruction: [7:5] opcode, [4:0] operand; sampled with ena_
//  opr      out  5  latched operand ins_q[4:0], always driven (not tri-state)
//  ex_ena_  out  7  per-opcode execute enables, bit n = opcode n; 0 or Z per bit
//  ex_rdy_  in   1  wired rdy_ from all execute steps (pulled up when idle)
//  fault_   out  1  sticky hung-step flag: 0 once set, else Z
// BEHAVIOUR
//  Reset (rst_ low, async): state=IDLE, ins_q=0, cnt=0.
//  Reset values: rdy_, ex_ena_, fault_ = Z; opr = 0.
//  All output enables are registered; no combinational path from any input to any output.
//  States: IDLE, DISP, WAIT, DONE. Transitions are evaluated on each posedge clk.
//  Highest priority, any state: ena_ low -> ins_q<=ins, cnt<=0.
//    Then state<=DONE if ins[7:5]==NOP_OP, else state<=DISP.
//    An in-flight operation is abandoned; its later ex_rdy_ is only honoured if it lands in the new WAIT.
//  IDLE: hold; ex_rdy_ ignored.
//  DISP: ex_ena_[ins_q[7:5]] = 0 for exactly this one cycle. Next edge -> WAIT, cnt<=0.
//  WAIT:
//    ex_rdy_ sampled low -> DONE.
//    Else cnt==TIMEOUT-1 -> fault_ set, DONE.
//    Else cnt<=cnt+1.
//    cnt is 8 bits and never wraps, because the TIMEOUT compare exits first.
//  DONE: rdy_ = 0 for exactly this one cycle. Next edge -> IDLE.
//  Latency, ena_ sampled at edge k:
//    ex_ena_ low during cycle k..k+1.
//    If ex_rdy_ is sampled low at edge m, rdy_ is low during m..m+1.
//    NOP: rdy_ low during k..k+1; no ex_ena_ bit ever asserted.
//  At most one ex_ena_ bit is low at any time.
//  fault_ is cleared only by rst_, not by ena_.
//  opr changes only on accepted ena_; it is stable through DISP, WAIT and DONE.
//  ex_rdy_ low in IDLE, DISP or DONE: ignored. The same cycle as ena_ low: ena_ wins.
// TESTING
//  1) ins=8'h00, ena_ low at edge 0, ex_rdy_ low at edge 4.
//     -> ex_ena_[0]=0 in cycle 0-1 only; rdy_=0 in cycle 4-5 only; opr=0; fault_ Z.
//  2) ins=8'hE5 (NOP).
//     -> rdy_=0 in cycle 0-1; ex_ena_ all Z throughout; opr=5'h05.
//  3) TIMEOUT=4, ins=8'h40, ex_rdy_ held high.
//     -> ex_ena_[2] pulse, then 4 WAIT cycles, then fault_=0 and a rdy_ pulse.
//     -> fault_ stays 0 across a following NOP until rst_.
//  4) ins=8'h40 dispatched; ena_ low in WAIT with ins=8'h21.
//     -> ex_ena_[1]=0 the next cycle; opr=5'h01; cnt restarts; the old op completes nothing.
//  5) rst_ low asynchronously during DISP.
//     -> ex_ena_, rdy_, fault_ go Z and opr=0 immediately, without a clock; state is IDLE after rst_ high.
//  6) ex_rdy_ low while IDLE, and ena_+ex_rdy_ low on the same edge.
//     -> no rdy_ pulse; the new dispatch proceeds normally.

Source files
------------

// File: rtl/step_id.sv
`default_nettype none
// ============================================================================
// Module   : step_id
// Brief    : Instruction dispatch step; strobes one execute step, waits for its
//            open-drain ready, and hands an open-drain ready back to fetch.
// Revision : 1.0
// ============================================================================
module step_id #(
    parameter logic [7:0] TIMEOUT = 8'd255,
    parameter logic [2:0] NOP_OP  = 3'd7
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       ena_,
    output tri         rdy_,
    input  logic [7:0] ins,
    output logic [4:0] opr,
    output tri   [6:0] ex_ena_,
    input  logic       ex_rdy_,
    output tri         fault_
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DISP = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0] state;
    logic [7:0] ins_q;
    logic [7:0] cnt;
    logic       fault_q;
    logic       rdy_en;
    logic [6:0] ex_en;
    logic [6:0] dec;

    // Opcode 7 shifts out of the 7-bit vector, so it never enables a step.
    assign dec = 7'd1 << ins[7:5];

    // Output enables live in their own flops so no input reaches an output
    // through logic.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state   <= IDLE;
            ins_q   <= 8'd0;
            cnt     <= 8'd0;
            fault_q <= 1'b0;
            rdy_en  <= 1'b0;
            ex_en   <= 7'd0;
        end else if (!ena_) begin
            ins_q <= ins;
            cnt   <= 8'd0;
            if (ins[7:5] == NOP_OP) begin
                state  <= DONE;
                rdy_en <= 1'b1;
                ex_en  <= 7'd0;
            end else begin
                state  <= DISP;
                rdy_en <= 1'b0;
                ex_en  <= dec;
            end
        end else begin
            rdy_en <= 1'b0;
            ex_en  <= 7'd0;
            case (state)
                DISP: begin
                    state <= WAIT;
                    cnt   <= 8'd0;
                end
                WAIT: begin
                    if (!ex_rdy_) begin
                        state  <= DONE;
                        rdy_en <= 1'b1;
                    end else if (cnt == TIMEOUT - 8'd1) begin
                        state   <= DONE;
                        rdy_en  <= 1'b1;
                        fault_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign opr    = ins_q[4:0];
    assign rdy_   = rdy_en  ? 1'b0 : 1'bz;
    assign fault_ = fault_q ? 1'b0 : 1'bz;

    generate
        for (genvar g = 0; g < 7; g++) begin : g_ex_ena
            assign ex_ena_[g] = ex_en[g] ? 1'b0 : 1'bz;
        end
    endgenerate

endmodule
`default_nettype wire
